// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch stage.
// Holds the PC and fetches over a variable-latency req/ack memory handshake.
// It honours hazard-unit stalls and execute-stage redirects, and emits a NOP
// bubble whenever no real instruction is available.
// Handshake: a request is presented while IMem_Req=1 with IMem_Addr stable.
// It completes in the cycle IMem_Ack=1, and IMem_Rdata is valid in that same
// cycle; an ack may arrive in the cycle the request first appears. A request
// is never withdrawn before its ack. A redirect that arrives while a request is
// outstanding therefore drains that request first.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-redirect fault).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] BUBBLE_PC = 32'h2A2A_2A2A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_En,
    input  logic        PC_Src_E,
    input  logic [31:0] PC_Target_E,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Rdata,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F,
    output logic        Valid_F,
    output logic        IMem_Wait,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        Fetch_Misalign,
`endif
    output logic [1:0]  Dbg_State
);

    localparam logic [1:0] ST_REQ     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] ST_FAULT   = 2'd3;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_redirect_pc;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_hold_nxt;
    logic [31:0] w_redirect_nxt;
    logic [31:0] w_target;
    logic [31:0] w_landing;
    logic [1:0]  w_redirect_state;
    logic [1:0]  w_landing_state;
    logic        w_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        r_misalign;
    logic        w_misalign_nxt;

    // Keep the raw target so its low bits can be judged for a fault.
    assign w_target         = PC_Target_E;
    assign w_redirect_state = (w_target[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
    assign w_landing_state  = (w_landing[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
    assign Fetch_Misalign   = r_misalign;
`else
    // Without fault checking, targets are forced word aligned.
    assign w_target         = PC_Target_E & ~32'h0000_0003;
    assign w_redirect_state = ST_REQ;
    assign w_landing_state  = ST_REQ;
`endif

    // Where a drained redirect lands: the newest target wins if it coincides with the ack.
    assign w_landing = PC_Src_E ? w_target : r_redirect_pc;

    assign IMem_Req  = !RST && ((r_state == ST_REQ) || (r_state == ST_DISCARD));
    assign IMem_Addr = r_pc;
    assign Dbg_State = r_state;
    assign Valid_F   = w_valid;
    assign IMem_Wait = !w_valid;

    // Output mux: live memory data, held word, or the NOP bubble.
    always_comb begin
        w_valid = 1'b0;
        if (!RST && !PC_Src_E) begin
            case (r_state)
                ST_REQ:  w_valid = IMem_Ack;
                ST_HOLD: w_valid = 1'b1;
                default: w_valid = 1'b0;
            endcase
        end
        Instr_F     = NOP_INSTR;
        PC_F        = BUBBLE_PC;
        PC_Plus_4_F = BUBBLE_PC;
        if (w_valid) begin
            Instr_F     = (r_state == ST_HOLD) ? r_hold_instr : IMem_Rdata;
            PC_F        = r_pc;
            PC_Plus_4_F = r_pc + 32'd4;
        end
    end

    // Next-state logic: redirect beats ack and stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_nxt     = r_hold_instr;
        w_redirect_nxt = r_redirect_pc;
        case (r_state)
            ST_REQ: begin
                if (PC_Src_E) begin
                    if (IMem_Ack) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = w_redirect_state;
                    end else begin
                        w_redirect_nxt = w_target;
                        w_state_nxt    = ST_DISCARD;
                    end
                end else if (IMem_Ack) begin
                    if (Stall_En) begin
                        w_hold_nxt  = IMem_Rdata;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            ST_HOLD: begin
                if (PC_Src_E) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = w_redirect_state;
                end else if (!Stall_En) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (IMem_Ack) begin
                    w_pc_nxt    = w_landing;
                    w_state_nxt = w_landing_state;
                end else if (PC_Src_E) begin
                    w_redirect_nxt = w_target;
                end
            end
            default: begin
                if (PC_Src_E) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = w_redirect_state;
                end
            end
        endcase
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky fault flag: every redirect re-evaluates it, otherwise it holds.
    always_comb begin
        w_misalign_nxt = r_misalign;
        if (PC_Src_E) begin
            w_misalign_nxt = (w_target[1:0] != 2'b00);
        end
    end

    // Fault flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_hold_instr  <= NOP_INSTR;
            r_redirect_pc <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_hold_instr  <= w_hold_nxt;
            r_redirect_pc <= w_redirect_nxt;
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the RV32i pipeline. Holds the program counter, issues requests to instruction memory over a variable-latency req/ack handshake, and presents `Instr_F`, `PC_F` and `PC_Plus_4_F` to the IF/ID register. It handles hazard-unit stalls and execute-stage redirects, including discarding responses that are already in flight. Whenever no valid instruction is available, it emits the pipeline's NOP bubble.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `BUBBLE_PC`, default 32'h2A2A_2A2A: PC / PC+4 value driven with a bubble.

Ports:
- `CLK` in 1: clock; one clock domain, all state updates on posedge.
- `RST` in 1: synchronous, active-high reset.
- `Stall_En` in 1: hazard-unit stall; hold the current fetch output.
- `PC_Src_E` in 1: execute-stage redirect (taken branch/jump).
- `PC_Target_E` in 32: redirect target.
- `IMem_Req` out 1: memory request valid.
- `IMem_Addr` out 32: request address, word aligned.
- `IMem_Ack` in 1: response valid; `IMem_Rdata` is valid in the same cycle.
- `IMem_Rdata` in 32: instruction word.
- `Instr_F` out 32: instruction to IF/ID.
- `PC_F` out 32: PC of `Instr_F`.
- `PC_Plus_4_F` out 32: `PC_F + 4`, modulo 2^32.
- `Valid_F` out 1: `Instr_F` is a real instruction.
- `IMem_Wait` out 1: equals `!Valid_F`; fetch is starved (to the hazard unit).

## Operation
- Registers:
  - `PC`: 32 bits.
  - `Hold_Instr`: 32 bits.
  - `Redirect_PC`: 32 bits.
  - `state`: one of `REQ`, `HOLD`, `DISCARD`.
- Memory protocol:
  - `IMem_Req` and `IMem_Addr` stay stable until an `IMem_Ack` cycle.
  - Ack may arrive in the same cycle `Req` rises (zero wait).
  - A transaction cannot be cancelled once issued.
- `REQ` state:
  - `IMem_Req=1`, `IMem_Addr=PC`.
  - On ack with `Stall_En=0`:
    - `Instr_F=IMem_Rdata`, `PC_F=PC`, `Valid_F=1` (combinational pass-through).
    - `PC<=PC+4`; stay in `REQ`.
  - On ack with `Stall_En=1`:
    - `Hold_Instr<=IMem_Rdata`; go to `HOLD`.
    - Outputs in that cycle are the live data with `Valid_F=1`.
- `HOLD` state:
  - `IMem_Req=0`; outputs come from `Hold_Instr`/`PC` with `Valid_F=1`.
  - When `Stall_En=0`: `PC<=PC+4`, go to `REQ`.
- `DISCARD` state:
  - `IMem_Req=1`, `IMem_Addr` = old `PC`; `Valid_F=0`.
  - On ack: drop the data, `PC<=Redirect_PC`, go to `REQ`.
- Redirect (`PC_Src_E=1`) has priority over `Stall_En` and ack:
  - `Valid_F` is forced to 0 in that cycle, and any held instruction is dropped.
  - From `REQ` without ack: `Redirect_PC<=PC_Target_E`, go to `DISCARD`.
  - From `REQ` with ack, or from `HOLD`: `PC<=PC_Target_E`, go to `REQ`.
  - In `DISCARD`: `Redirect_PC` is overwritten by the newest target.
- Bubble: when `Valid_F=0`, `Instr_F=NOP_INSTR` and `PC_F=PC_Plus_4_F=BUBBLE_PC`.
- `PC_Target_E[1:0]` handling is set by the configuration macro below.

## Timing
- Reset values:
  - `PC=RESET_PC`, `state=REQ`.
  - `IMem_Req=0` while `RST=1`; `Valid_F=0`, `IMem_Wait=1`.
  - Outputs show the bubble values.
- First request: the first cycle after `RST` falls.
- With zero-wait memory, one instruction is delivered per cycle and fetch-to-IF/ID latency is 0 cycles (combinational).
- Each wait state adds one bubble cycle.
- A redirect with an in-flight request costs the remaining wait cycles plus one.
- Reset mid-transaction abandons the request; the memory shares `RST`.
- PC wrap: `32'hFFFF_FFFC + 4` gives `32'h0000_0000`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - Adds output `Fetch_Misalign` (1 bit, resets to 0).
  - A redirect with `PC_Target_E[1:0]!=0` sets `Fetch_Misalign` sticky and moves to a `FAULT` state.
  - In `FAULT`: `IMem_Req=0` and bubbles only.
  - A later aligned redirect clears `FAULT` and `Fetch_Misalign`; reset also clears them.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - The target's low two bits are forced to 00; there is no `FAULT` state or port.

## Test plan
- Reset with zero-wait memory returning `addr^32'hA5A5_0000`: after reset, consecutive cycles deliver `PC_F` 0, 4, 8, 12 with matching `Instr_F` and `Valid_F=1`.
- Memory with 2 wait states: `Valid_F` is 0, 0, 1 repeating; bubble cycles show `Instr_F=0x00000013` and `PC_F=0x2A2A2A2A`.
- `Stall_En=1` for 3 cycles on an ack at `PC 0x10`: `Instr_F`/`PC_F` hold at 0x10 with `IMem_Req=0`; after release, the next fetch is `0x14`.
- Redirect to `0x100` while a request to `0x20` waits 3 cycles: the `0x20` data never appears, `IMem_Addr` stays `0x20` until ack, and the next delivered `PC_F` is `0x100`.
- Redirect and `Stall_En` in the same cycle from `HOLD`: the held instruction is dropped and fetch resumes at the target.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to `0x102`: `Fetch_Misalign=1` with bubbles only; a redirect to `0x200` clears the fault and fetches `0x200`. Without the macro, the same redirect fetches `0x100`.
